sync_multi_port_ram: RTL and testbench
======================================

// Module: sync_multi_port_ram
// PURPOSE
//   Parametrised synchronous RAM: one byte-enabled write port, NUM_RD_PORTS independent read ports.
//   Adds per-port read enables, read-valid flags, optional output register, and a hardware clear
//   sequencer that zeroes the array after reset. Next-generation replacement for the fixed two-read-port RAM
//   in register-file and predictor-table storage.
// PARAMETERS
//   ADDR_WIDTH     10    address width, all ports
//   DATA_DEPTH     1024  number of words; must satisfy DATA_DEPTH <= 2**ADDR_WIDTH
//   DATA_WIDTH     32    word width; must be a multiple of 8
//   NUM_RD_PORTS   2     number of read ports, >= 1
//   OUT_REG        0     1 = extra output register stage (read latency 2)
//   CLEAR_ON_RESET 1     1 = zero all words after reset; 0 = skip clear, contents undefined
// PORTS
//   Clk_CI       in   1                          clock, rising edge
//   Rst_RBI      in   1                          asynchronous reset, active low
//   InitDone_SO  out  1                          1 = clear finished, ports accept requests
//   WrEn_SI      in   1                          write request
//   WrAddr_DI    in   ADDR_WIDTH                 write address
//   WrBe_DI      in   DATA_WIDTH/8               byte enables, bit i -> WrData_DI[8i+7:8i]
//   WrData_DI    in   DATA_WIDTH                 write data
//   RdEn_SI      in   NUM_RD_PORTS               per-port read request
//   RdAddr_DI    in   NUM_RD_PORTS x ADDR_WIDTH  per-port read address
//   RdData_DO    out  NUM_RD_PORTS x DATA_WIDTH  per-port read data
//   RdValid_SO   out  NUM_RD_PORTS               per-port: RdData_DO holds the response to a request
// BEHAVIOUR
//   - Reset (Rst_RBI=0): InitDone_SO=0, RdValid_SO=0, RdData_DO=0, clear counter=0. Array not reset.
//   - FSM: CLEAR -> READY. After reset release, if CLEAR_ON_RESET=1 state CLEAR writes 0 to address cnt
//     each cycle, cnt 0..DATA_DEPTH-1; after writing DATA_DEPTH-1 -> READY (DATA_DEPTH cycles total).
//     If CLEAR_ON_RESET=0 the first cycle after release enters READY.
//   - InitDone_SO=1 only in READY. In CLEAR, WrEn_SI and RdEn_SI are ignored; RdValid_SO stays 0.
//   - Reset asserted mid-clear: immediate return to reset values; clear restarts from address 0.
//   - Write (READY, WrEn_SI=1): at the clock edge, each byte i with WrBe_DI[i]=1 is updated; other bytes kept.
//     WrBe_DI=0 is a legal no-op.
//   - Read (READY, RdEn_SI[p]=1) at edge N: OUT_REG=0 -> RdData_DO[p]=mem[addr], RdValid_SO[p]=1
//     after edge N; OUT_REG=1 -> same values one edge later (N+1). Fully pipelined: one request/port/cycle.
//   - RdEn_SI[p]=0: RdValid_SO[p]=0 in matching slot; RdData_DO[p] holds its last value (no power toggling).
//   - Read/write same address, same edge: read-first; read returns pre-write contents.
//   - Multiple read ports, same address: all return the same word; no arbitration, no stall.
//   - Address >= DATA_DEPTH: write dropped; read returns 0 with RdValid_SO=1.
//   - Clear and user-write never overlap (writes are ignored in CLEAR).
//   - Simulation-only assertions: DATA_DEPTH <= 2**ADDR_WIDTH, DATA_WIDTH%8==0, NUM_RD_PORTS>=1.
// TESTING
//   1 Clear: DATA_DEPTH=16, release reset -> InitDone_SO rises after exactly 16 cycles;
//     then read all 16 addresses -> all 0x00000000.
//   2 Byte enables: write 0xAABBCCDD @5 BE=4'hF, then 0x11223344 @5 BE=4'b0101
//     -> read @5 = 0xAA22CC44.
//   3 Collision: mem[3]=0x1; same edge write 0x2 @3 and read @3 on port 0 -> 0x1;
//     next-cycle read -> 0x2.
//   4 Multi-port, OUT_REG=1, NUM_RD_PORTS=4: four ports read 0,1,2,3 on one edge
//     -> all four RdValid_SO=1 two edges later with correct data; RdEn=0 next cycle -> valid 0, data held.
//   5 Out of range: DATA_DEPTH=12, ADDR_WIDTH=4: write @14 then read @14 -> 0, RdValid=1;
//     addresses 0..11 unchanged.
//   6 Reset mid-clear: assert Rst_RBI at clear count 7 -> outputs reset at once;
//     release -> full DATA_DEPTH-cycle clear, earlier writes absent.

Source files
------------

// File: rtl/sync_multi_port_ram_if.sv
// sync_multi_port_ram_if: write port, per-port read request/response and init status of sync_multi_port_ram
//   master : requester side (drives WrEn/WrAddr/WrBe/WrData, RdEn/RdAddr; observes InitDone/RdData/RdValid)
//   slave  : RAM side (the reverse)
interface sync_multi_port_ram_if #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_RD_PORTS = 2
);
   logic                                    InitDone_SO;
   logic                                    WrEn_SI;
   logic [ADDR_WIDTH-1:0]                   WrAddr_DI;
   logic [DATA_WIDTH/8-1:0]                 WrBe_DI;
   logic [DATA_WIDTH-1:0]                   WrData_DI;
   logic [NUM_RD_PORTS-1:0]                 RdEn_SI;
   logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] RdAddr_DI;
   logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] RdData_DO;
   logic [NUM_RD_PORTS-1:0]                 RdValid_SO;
   modport master (
      input  InitDone_SO, RdData_DO, RdValid_SO,
      output WrEn_SI, WrAddr_DI, WrBe_DI, WrData_DI, RdEn_SI, RdAddr_DI
   );
   modport slave (
      output InitDone_SO, RdData_DO, RdValid_SO,
      input  WrEn_SI, WrAddr_DI, WrBe_DI, WrData_DI, RdEn_SI, RdAddr_DI
   );
endinterface

// File: rtl/sync_multi_port_ram.sv
// sync_multi_port_ram: byte-enabled single-write, multi-read synchronous RAM with post-reset clear
//   Clk_CI  : clock, rising edge
//   Rst_RBI : asynchronous reset, active low
//   bus     : slave side of sync_multi_port_ram_if (InitDone_SO, write port, NUM_RD_PORTS read ports)
module sync_multi_port_ram #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_DEPTH     = 1024,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_RD_PORTS   = 2,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic                  Clk_CI,
   input logic                  Rst_RBI,
   sync_multi_port_ram_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   typedef enum logic {S_CLEAR, S_READY} state_t;
   state_t                                  r_state;
   logic                                    r_init_done;
   logic [ADDR_WIDTH-1:0]                   r_cnt;
   logic [DATA_WIDTH-1:0]                   r_mem [DATA_DEPTH];
   logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] r_rd_data;
   logic [NUM_RD_PORTS-1:0]                 r_rd_valid;
   logic                                    w_ready;
   logic                                    w_clr;
   logic [NB-1:0]                           w_wbe;
   logic [ADDR_WIDTH-1:0]                   w_waddr;
   logic [DATA_WIDTH-1:0]                   w_wdata;

   function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
      return int'(a) < DATA_DEPTH;
   endfunction

   always_ff @(posedge Clk_CI or negedge Rst_RBI)
      if (!Rst_RBI) begin
         r_state     <= S_CLEAR;
         r_cnt       <= '0;
         r_init_done <= 1'b0;
      end else if (r_state == S_CLEAR) begin
         if (CLEAR_ON_RESET == 0 || r_cnt == ADDR_WIDTH'(DATA_DEPTH - 1)) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
         end else
            r_cnt <= r_cnt + 1'b1;
      end

   assign w_ready = r_state == S_READY;
   // clear is gated by reset so a held reset never disturbs the array
   assign w_clr   = (CLEAR_ON_RESET != 0) && Rst_RBI && r_state == S_CLEAR;
   assign w_waddr = w_clr ? r_cnt : bus.WrAddr_DI;
   assign w_wdata = w_clr ? '0 : bus.WrData_DI;
   assign w_wbe   = w_clr ? '1 : (w_ready && bus.WrEn_SI && f_in_range(bus.WrAddr_DI)) ? bus.WrBe_DI : '0;

   always_ff @(posedge Clk_CI)
      for (int b = 0; b < NB; b++)
         if (w_wbe[b]) r_mem[w_waddr[IW-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];

   // nonblocking read of r_mem gives read-first behaviour on a same-edge collision
   always_ff @(posedge Clk_CI or negedge Rst_RBI)
      if (!Rst_RBI) begin
         r_rd_data  <= '0;
         r_rd_valid <= '0;
      end else
         for (int p = 0; p < NUM_RD_PORTS; p++) begin
            r_rd_valid[p] <= w_ready && bus.RdEn_SI[p];
            if (w_ready && bus.RdEn_SI[p])
               r_rd_data[p] <= f_in_range(bus.RdAddr_DI[p]) ? r_mem[bus.RdAddr_DI[p][IW-1:0]] : '0;
         end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] r_out_data;
         logic [NUM_RD_PORTS-1:0]                 r_out_valid;
         always_ff @(posedge Clk_CI or negedge Rst_RBI)
            if (!Rst_RBI) begin
               r_out_data  <= '0;
               r_out_valid <= '0;
            end else begin
               r_out_valid <= r_rd_valid;
               for (int p = 0; p < NUM_RD_PORTS; p++)
                  if (r_rd_valid[p]) r_out_data[p] <= r_rd_data[p];
            end
         assign bus.RdData_DO  = r_out_data;
         assign bus.RdValid_SO = r_out_valid;
      end else begin : g_noreg
         assign bus.RdData_DO  = r_rd_data;
         assign bus.RdValid_SO = r_rd_valid;
      end
   endgenerate

   assign bus.InitDone_SO = r_init_done;

   a_params: assert property (@(posedge Clk_CI)
      (DATA_DEPTH <= 2 ** ADDR_WIDTH) && (DATA_WIDTH % 8 == 0) && (NUM_RD_PORTS >= 1));
endmodule

// File: tb/tb_sync_multi_port_ram.sv
// tb_sync_multi_port_ram: directed and randomized checks of sync_multi_port_ram against a behavioural model
module tb_sync_multi_port_ram;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [31:0] ma [16];
   logic [31:0] mb [12];
   typedef struct packed {
      logic [3:0]       v;
      logic [3:0][31:0] d;
   } resp_t;

   always #5 clk = ~clk;

   sync_multi_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_RD_PORTS(2)) ifa ();
   sync_multi_port_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_RD_PORTS(4)) ifb ();
   sync_multi_port_ram_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .NUM_RD_PORTS(1)) ifc ();

   sync_multi_port_ram #(.ADDR_WIDTH(4), .DATA_DEPTH(16), .DATA_WIDTH(32), .NUM_RD_PORTS(2),
      .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(ifa));
   sync_multi_port_ram #(.ADDR_WIDTH(4), .DATA_DEPTH(12), .DATA_WIDTH(32), .NUM_RD_PORTS(4),
      .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(ifb));
   sync_multi_port_ram #(.ADDR_WIDTH(3), .DATA_DEPTH(8), .DATA_WIDTH(32), .NUM_RD_PORTS(1),
      .OUT_REG(0), .CLEAR_ON_RESET(0)) dut_c (.Clk_CI(clk), .Rst_RBI(rst_n), .bus(ifc));

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      for (int b = 0; b < 4; b++)
         if (be[b]) old[8*b +: 8] = d[8*b +: 8];
      return old;
   endfunction

   task automatic idle();
      ifa.WrEn_SI = 1'b0;
      ifa.RdEn_SI = '0;
      ifb.WrEn_SI = 1'b0;
      ifb.RdEn_SI = '0;
      ifc.WrEn_SI = 1'b0;
      ifc.RdEn_SI = '0;
   endtask

   task automatic wr_a(input int addr, input logic [3:0] be, input logic [31:0] d);
      ifa.WrEn_SI = 1'b1;
      ifa.WrAddr_DI = 4'(addr);
      ifa.WrBe_DI = be;
      ifa.WrData_DI = d;
      @(negedge clk);
      ifa.WrEn_SI = 1'b0;
      ma[addr] = merge(ma[addr], d, be);
   endtask

   task automatic wr_b(input int addr, input logic [3:0] be, input logic [31:0] d);
      ifb.WrEn_SI = 1'b1;
      ifb.WrAddr_DI = 4'(addr);
      ifb.WrBe_DI = be;
      ifb.WrData_DI = d;
      @(negedge clk);
      ifb.WrEn_SI = 1'b0;
      if (addr < 12) mb[addr] = merge(mb[addr], d, be);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      checks++;
      if (ifa.InitDone_SO !== 1'b0) begin errors++; $display("FAIL reset_initdone_a got=%b exp=0", ifa.InitDone_SO); end
      checks++;
      if (ifa.RdValid_SO !== 2'b00) begin errors++; $display("FAIL reset_valid_a got=%b exp=00", ifa.RdValid_SO); end
      checks++;
      if (ifa.RdData_DO !== '0) begin errors++; $display("FAIL reset_data_a got=%h exp=0", ifa.RdData_DO); end
      checks++;
      if (ifb.InitDone_SO !== 1'b0) begin errors++; $display("FAIL reset_initdone_b got=%b exp=0", ifb.InitDone_SO); end
      checks++;
      if (ifb.RdValid_SO !== 4'h0) begin errors++; $display("FAIL reset_valid_b got=%b exp=0000", ifb.RdValid_SO); end
      checks++;
      if (ifb.RdData_DO !== '0) begin errors++; $display("FAIL reset_data_b got=%h exp=0", ifb.RdData_DO); end
      checks++;
      if (ifc.InitDone_SO !== 1'b0) begin errors++; $display("FAIL reset_initdone_c got=%b exp=0", ifc.InitDone_SO); end
   endtask

   task automatic test_clear();
      int ta = 0, tb = 0, tc = 0;
      for (int a = 0; a < 16; a++) ma[a] = '0;
      for (int a = 0; a < 12; a++) mb[a] = '0;
      rst_n = 1'b1;
      ifa.RdEn_SI = 2'b11;
      ifa.RdAddr_DI = '0;
      ifa.WrAddr_DI = '0;
      ifa.WrBe_DI = 4'hF;
      ifa.WrData_DI = 32'hFFFF_FFFF;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ifa.InitDone_SO === 1'b1 && ta == 0) ta = k;
         if (ifb.InitDone_SO === 1'b1 && tb == 0) tb = k;
         if (ifc.InitDone_SO === 1'b1 && tc == 0) tc = k;
         if (ifa.InitDone_SO !== 1'b1) begin
            checks++;
            if (ifa.RdValid_SO !== 2'b00) begin errors++; $display("FAIL clear_valid_a cycle=%0d got=%b exp=00", k, ifa.RdValid_SO); end
         end
         ifa.RdEn_SI = (k < 15) ? 2'b11 : 2'b00;
         ifa.WrEn_SI = k < 15;
      end
      checks++;
      if (ta != 16) begin errors++; $display("FAIL clear_cycles_a got=%0d exp=16", ta); end
      checks++;
      if (tb != 12) begin errors++; $display("FAIL clear_cycles_b got=%0d exp=12", tb); end
      checks++;
      if (tc != 1) begin errors++; $display("FAIL noclear_cycles_c got=%0d exp=1", tc); end
      for (int i = 0; i < 8; i++) begin
         ifa.RdEn_SI = 2'b11;
         ifa.RdAddr_DI[0] = 4'(2 * i);
         ifa.RdAddr_DI[1] = 4'(2 * i + 1);
         @(negedge clk);
         idle();
         checks++;
         if (ifa.RdValid_SO !== 2'b11 || ifa.RdData_DO !== '0)
            begin errors++; $display("FAIL clear_read_a addr=%0d got=%b/%h exp=11/0", 2 * i, ifa.RdValid_SO, ifa.RdData_DO); end
      end
      for (int r = 0; r < 3; r++) begin
         ifb.RdEn_SI = 4'hF;
         for (int p = 0; p < 4; p++) ifb.RdAddr_DI[p] = 4'(4 * r + p);
         @(negedge clk);
         idle();
         @(negedge clk);
         checks++;
         if (ifb.RdValid_SO !== 4'hF || ifb.RdData_DO !== '0)
            begin errors++; $display("FAIL clear_read_b addr=%0d got=%b/%h exp=1111/0", 4 * r, ifb.RdValid_SO, ifb.RdData_DO); end
      end
   endtask

   task automatic test_byte_enable();
      wr_a(5, 4'hF, 32'hAABB_CCDD);
      wr_a(5, 4'b0101, 32'h1122_3344);
      ifa.RdEn_SI = 2'b10;
      ifa.RdAddr_DI[1] = 4'd5;
      @(negedge clk);
      idle();
      checks++;
      if (ifa.RdValid_SO !== 2'b10) begin errors++; $display("FAIL be_valid got=%b exp=10", ifa.RdValid_SO); end
      checks++;
      if (ifa.RdData_DO[1] !== 32'hAA22_CC44) begin errors++; $display("FAIL be_merge got=%h exp=aa22cc44", ifa.RdData_DO[1]); end
      wr_a(5, 4'h0, 32'hFFFF_FFFF);
      ifa.RdEn_SI = 2'b01;
      ifa.RdAddr_DI[0] = 4'd5;
      @(negedge clk);
      idle();
      checks++;
      if (ifa.RdData_DO[0] !== 32'hAA22_CC44) begin errors++; $display("FAIL be_zero_noop got=%h exp=aa22cc44", ifa.RdData_DO[0]); end
   endtask

   task automatic test_collision();
      wr_a(3, 4'hF, 32'h1);
      ifa.WrEn_SI = 1'b1;
      ifa.WrAddr_DI = 4'd3;
      ifa.WrBe_DI = 4'hF;
      ifa.WrData_DI = 32'h2;
      ifa.RdEn_SI = 2'b01;
      ifa.RdAddr_DI[0] = 4'd3;
      @(negedge clk);
      idle();
      ma[3] = 32'h2;
      checks++;
      if (ifa.RdValid_SO !== 2'b01 || ifa.RdData_DO[0] !== 32'h1)
         begin errors++; $display("FAIL collision_read_first got=%b/%h exp=01/00000001", ifa.RdValid_SO, ifa.RdData_DO[0]); end
      ifa.RdEn_SI = 2'b11;
      ifa.RdAddr_DI[0] = 4'd3;
      ifa.RdAddr_DI[1] = 4'd3;
      @(negedge clk);
      idle();
      checks++;
      if (ifa.RdValid_SO !== 2'b11 || ifa.RdData_DO !== {32'h2, 32'h2})
         begin errors++; $display("FAIL collision_after got=%b/%h exp=11/both 00000002", ifa.RdValid_SO, ifa.RdData_DO); end
      @(negedge clk);
      checks++;
      if (ifa.RdValid_SO !== 2'b00 || ifa.RdData_DO !== {32'h2, 32'h2})
         begin errors++; $display("FAIL hold_a got=%b/%h exp=00/both 00000002", ifa.RdValid_SO, ifa.RdData_DO); end
   endtask

   task automatic test_multiport();
      for (int i = 0; i < 4; i++) wr_b(i, 4'hF, $urandom);
      ifb.RdEn_SI = 4'hF;
      for (int p = 0; p < 4; p++) ifb.RdAddr_DI[p] = 4'(3 - p);
      @(negedge clk);
      idle();
      checks++;
      if (ifb.RdValid_SO !== 4'h0) begin errors++; $display("FAIL mp_latency got=%b exp=0000", ifb.RdValid_SO); end
      @(negedge clk);
      checks++;
      if (ifb.RdValid_SO !== 4'hF) begin errors++; $display("FAIL mp_valid got=%b exp=1111", ifb.RdValid_SO); end
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (ifb.RdData_DO[p] !== mb[3 - p]) begin errors++; $display("FAIL mp_data port=%0d got=%h exp=%h", p, ifb.RdData_DO[p], mb[3 - p]); end
      end
      @(negedge clk);
      checks++;
      if (ifb.RdValid_SO !== 4'h0 || ifb.RdData_DO !== {mb[0], mb[1], mb[2], mb[3]})
         begin errors++; $display("FAIL mp_hold got=%b/%h exp=0000/%h", ifb.RdValid_SO, ifb.RdData_DO, {mb[0], mb[1], mb[2], mb[3]}); end
   endtask

   task automatic test_out_of_range();
      wr_b(14, 4'hF, 32'hDEAD_BEEF);
      wr_b(12, 4'hF, 32'hCAFE_F00D);
      ifb.RdEn_SI = 4'b0101;
      ifb.RdAddr_DI[0] = 4'd14;
      ifb.RdAddr_DI[2] = 4'd12;
      @(negedge clk);
      idle();
      @(negedge clk);
      checks++;
      if (ifb.RdValid_SO !== 4'b0101 || ifb.RdData_DO[0] !== '0 || ifb.RdData_DO[2] !== '0)
         begin errors++; $display("FAIL oor_read got=%b/%h/%h exp=0101/0/0", ifb.RdValid_SO, ifb.RdData_DO[0], ifb.RdData_DO[2]); end
      for (int r = 0; r < 3; r++) begin
         ifb.RdEn_SI = 4'hF;
         for (int p = 0; p < 4; p++) ifb.RdAddr_DI[p] = 4'(4 * r + p);
         @(negedge clk);
         idle();
         @(negedge clk);
         checks++;
         if (ifb.RdData_DO !== {mb[4 * r + 3], mb[4 * r + 2], mb[4 * r + 1], mb[4 * r]})
            begin errors++; $display("FAIL oor_intact base=%0d got=%h exp=%h", 4 * r, ifb.RdData_DO, {mb[4 * r + 3], mb[4 * r + 2], mb[4 * r + 1], mb[4 * r]}); end
      end
   endtask

   task automatic test_random();
      resp_t ra, rb, rq;
      resp_t qb [$];
      logic [1:0]       ea_v = '0;
      logic [1:0][31:0] ea_d = '0;
      logic [3:0]       eb_v = '0;
      logic [3:0][31:0] eb_d = '0;
      for (int i = 0; i < 400; i++) begin
         ifa.RdEn_SI = (i < 2) ? 2'b11 : 2'($urandom);
         ifb.RdEn_SI = (i < 2) ? 4'hF : 4'($urandom);
         ifa.WrEn_SI = 1'($urandom);
         ifa.WrAddr_DI = 4'($urandom);
         ifa.WrBe_DI = 4'($urandom);
         ifa.WrData_DI = $urandom;
         ifb.WrEn_SI = 1'($urandom);
         ifb.WrAddr_DI = 4'($urandom);
         ifb.WrBe_DI = 4'($urandom);
         ifb.WrData_DI = $urandom;
         ra = '0;
         rb = '0;
         for (int p = 0; p < 4; p++) begin
            ifb.RdAddr_DI[p] = 4'($urandom);
            if (ifb.RdEn_SI[p]) begin
               rb.v[p] = 1'b1;
               rb.d[p] = (ifb.RdAddr_DI[p] < 12) ? mb[ifb.RdAddr_DI[p]] : '0;
            end
            if (p < 2) begin
               ifa.RdAddr_DI[p] = 4'($urandom);
               if (ifa.RdEn_SI[p]) begin
                  ra.v[p] = 1'b1;
                  ra.d[p] = ma[ifa.RdAddr_DI[p]];
               end
            end
         end
         if (ifa.WrEn_SI) ma[ifa.WrAddr_DI] = merge(ma[ifa.WrAddr_DI], ifa.WrData_DI, ifa.WrBe_DI);
         if (ifb.WrEn_SI && ifb.WrAddr_DI < 12) mb[ifb.WrAddr_DI] = merge(mb[ifb.WrAddr_DI], ifb.WrData_DI, ifb.WrBe_DI);
         qb.push_back(rb);
         @(negedge clk);
         ea_v = ra.v[1:0];
         for (int p = 0; p < 2; p++) if (ra.v[p]) ea_d[p] = ra.d[p];
         eb_v = '0;
         if (qb.size() == 2) begin
            rq = qb.pop_front();
            eb_v = rq.v;
            for (int p = 0; p < 4; p++) if (rq.v[p]) eb_d[p] = rq.d[p];
         end
         if (i >= 2) begin
            checks++;
            if (ifa.RdValid_SO !== ea_v) begin errors++; $display("FAIL rand_valid_a i=%0d got=%b exp=%b", i, ifa.RdValid_SO, ea_v); end
            checks++;
            if (ifa.RdData_DO !== ea_d) begin errors++; $display("FAIL rand_data_a i=%0d got=%h exp=%h", i, ifa.RdData_DO, ea_d); end
            checks++;
            if (ifb.RdValid_SO !== eb_v) begin errors++; $display("FAIL rand_valid_b i=%0d got=%b exp=%b", i, ifb.RdValid_SO, eb_v); end
            checks++;
            if (ifb.RdData_DO !== eb_d) begin errors++; $display("FAIL rand_data_b i=%0d got=%h exp=%h", i, ifb.RdData_DO, eb_d); end
         end
      end
      idle();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_clear();
      int ta = 0, tb = 0;
      for (int a = 7; a < 16; a++) wr_a(a, 4'hF, 32'hC0DE_0000 | 32'(a));
      ifa.RdEn_SI = 2'b01;
      ifa.RdAddr_DI[0] = 4'd9;
      @(negedge clk);
      idle();
      checks++;
      if (ifa.RdData_DO[0] !== 32'hC0DE_0009) begin errors++; $display("FAIL pre_reset_read got=%h exp=c0de0009", ifa.RdData_DO[0]); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ifa.InitDone_SO, ifa.RdValid_SO, ifa.RdData_DO} !== '0)
         begin errors++; $display("FAIL async_reset_a got=%b/%b/%h exp=all 0", ifa.InitDone_SO, ifa.RdValid_SO, ifa.RdData_DO); end
      checks++;
      if ({ifb.InitDone_SO, ifb.RdValid_SO, ifb.RdData_DO} !== '0)
         begin errors++; $display("FAIL async_reset_b got=%b/%b/%h exp=all 0", ifb.InitDone_SO, ifb.RdValid_SO, ifb.RdData_DO); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (ifa.InitDone_SO !== 1'b0 || ifa.RdValid_SO !== 2'b00)
         begin errors++; $display("FAIL midclear_reset got=%b/%b exp=0/00", ifa.InitDone_SO, ifa.RdValid_SO); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ifa.InitDone_SO === 1'b1 && ta == 0) ta = k;
         if (ifb.InitDone_SO === 1'b1 && tb == 0) tb = k;
      end
      checks++;
      if (ta != 16) begin errors++; $display("FAIL reclear_cycles_a got=%0d exp=16", ta); end
      checks++;
      if (tb != 12) begin errors++; $display("FAIL reclear_cycles_b got=%0d exp=12", tb); end
      for (int i = 0; i < 8; i++) begin
         ifa.RdEn_SI = 2'b11;
         ifa.RdAddr_DI[0] = 4'(2 * i);
         ifa.RdAddr_DI[1] = 4'(2 * i + 1);
         @(negedge clk);
         idle();
         checks++;
         if (ifa.RdData_DO !== '0) begin errors++; $display("FAIL reclear_read_a addr=%0d got=%h exp=0", 2 * i, ifa.RdData_DO); end
      end
   endtask

   initial begin
      idle();
      ifa.WrAddr_DI = '0; ifa.WrBe_DI = '0; ifa.WrData_DI = '0; ifa.RdAddr_DI = '0;
      ifb.WrAddr_DI = '0; ifb.WrBe_DI = '0; ifb.WrData_DI = '0; ifb.RdAddr_DI = '0;
      ifc.WrAddr_DI = '0; ifc.WrBe_DI = '0; ifc.WrData_DI = '0; ifc.RdAddr_DI = '0;
      test_reset();
      test_clear();
      test_byte_enable();
      test_collision();
      test_multiport();
      test_out_of_range();
      test_random();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
